// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu: iterative multiply/divide unit with HI/LO registers.
//
// Radix-2 shift-add multiply and restoring divide operate on operand
// magnitudes for 32 iterations. One final cycle applies the result signs and
// writes HI/LO.
//
// Optional feature macro: MDU_MADD_EN enables MADD (op 6) and MADDU (op 7).
// These accumulate the product into {hi,lo}. Without the macro, a start with
// op 6/7 is ignored.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   start  in   operation request, sampled on the rising edge
//   op     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
//   src0   in   rs operand (multiplicand / dividend / MTHI,MTLO data)
//   src1   in   rt operand (multiplier / divisor)
//   busy   out  high while a multi-cycle operation is in flight
//   done   out  one-cycle pulse after HI/LO were written by a multi-cycle op
//   hi     out  HI register
//   lo     out  LO register
//
// Handshake: start is a request that is accepted only while busy is low
// (state IDLE). Any start seen while busy is high is dropped, not queued.
// Operands are captured only at the accepting edge.
// -----------------------------------------------------------------------------
module mdu #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src0,
    input  logic [DATA_W-1:0] src1,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

`ifdef MDU_MADD_EN
    localparam logic MADD_EN = 1'b1;
`else
    localparam logic MADD_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;       // operand signs differ
    logic                rneg_q, rneg_d;     // dividend was negative
    logic                dz_q, dz_d;         // divide by zero
    logic [DATA_W-1:0]   addend_q, addend_d; // multiplicand or divisor magnitude
    logic [DATA_W-1:0]   shf_q, shf_d;       // multiplier or dividend magnitude, one bit consumed per iteration
    logic [2*DATA_W-1:0] work_q, work_d;     // product, or {remainder, quotient}
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;

    // ---------------- incoming operand decode ----------------
    logic              in_sgn, in_div, in_mdu;
    logic              src0_neg, src1_neg;
    logic [DATA_W-1:0] src0_mag, src1_mag;

    always_comb begin
        in_sgn   = ~op[0];                 // ops 0,2,6 are signed
        in_div   = ~op[2] & op[1];         // ops 2,3
        in_mdu   = ~op[2] | (MADD_EN & op[1]);
        src0_neg = in_sgn & src0[DATA_W-1];
        src1_neg = in_sgn & src1[DATA_W-1];
        src0_mag = src0_neg ? -src0 : src0;
        src1_mag = src1_neg ? -src1 : src1;
    end

    // ---------------- iteration datapath ----------------
    logic                q_div;
    logic [DATA_W:0]     mul_sum, mul_upper;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;
    logic [DATA_W-1:0]   div_diff, div_rem;

    always_comb begin
        q_div     = ~op_q[2] & op_q[1];
        // Multiply: add into the upper half with carry kept as the 33rd bit,
        // which becomes the MSB after the right shift.
        mul_sum   = {1'b0, work_q[2*DATA_W-1:DATA_W]} + {1'b0, addend_q};
        mul_upper = shf_q[0] ? mul_sum : {1'b0, work_q[2*DATA_W-1:DATA_W]};
        // Divide: the shifted remainder is below twice the divisor, so a
        // successful trial subtract always fits back into DATA_W bits.
        div_shift = {work_q[2*DATA_W-1:DATA_W], shf_q[DATA_W-1]};
        div_ge    = div_shift >= {1'b0, addend_q};
        div_diff  = div_shift[DATA_W-1:0] - addend_q;
        div_rem   = div_ge ? div_diff : div_shift[DATA_W-1:0];
    end

    // ---------------- sign fix ----------------
    logic [2*DATA_W-1:0] prod_fix, acc_sum;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod_fix = neg_q ? -work_q : work_q;
        acc_sum  = {hi_q, lo_q} + prod_fix;
        quo_fix  = neg_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
        rem_fix  = rneg_q ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        addend_d = addend_q;
        shf_d    = shf_q;
        work_d   = work_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (in_mdu) begin
                        op_d     = op;
                        neg_d    = src0_neg ^ src1_neg;
                        rneg_d   = src0_neg;
                        dz_d     = in_div & (src1 == '0);
                        addend_d = in_div ? src1_mag : src0_mag;
                        shf_d    = in_div ? src0_mag : src1_mag;
                        work_d   = '0;
                        cnt_d    = '0;
                        state_d  = S_CALC;
                    end else if (op == OP_MTHI) begin
                        hi_d = src0;
                    end else if (op == OP_MTLO) begin
                        lo_d = src0;
                    end
                end
            end
            S_CALC: begin
                if (q_div) begin
                    work_d = {div_rem, work_q[DATA_W-2:0], div_ge};
                    shf_d  = {shf_q[DATA_W-2:0], 1'b0};
                end else begin
                    work_d = {mul_upper, work_q[DATA_W-1:1]};
                    shf_d  = {1'b0, shf_q[DATA_W-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (q_div) begin
                    // Divide by zero leaves the magnitude remainder equal to
                    // |src0|, so the remainder sign rule returns src0 itself.
                    lo_d = dz_q ? '1 : quo_fix;
                    hi_d = rem_fix;
                end else if (op_q[2]) begin
                    {hi_d, lo_d} = acc_sum;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            addend_q <= '0;
            shf_q    <= '0;
            work_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            addend_q <= addend_d;
            shf_q    <= shf_d;
            work_q   <= work_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu: directed, table-driven bench for mdu.
// A vector table covers MULT/MULTU/DIV/DIVU, including sign combinations,
// divide by zero and the signed overflow case. Hand-written sequences cover
// the following:
//   - MTHI/MTLO
//   - start while busy
//   - mid-operation reset
//   - back-to-back issue
//   - MADD/MADDU (only when MDU_MADD_EN is defined)
// -----------------------------------------------------------------------------
module tb_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [2:0] MULT  = 3'd0;
    localparam logic [2:0] MULTU = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] DIVU  = 3'd3;
    localparam logic [2:0] MTHI  = 3'd4;
    localparam logic [2:0] MTLO  = 3'd5;
    localparam logic [2:0] MADD  = 3'd6;
    localparam logic [2:0] MADDU = 3'd7;

    // Start edge E0 through FIX edge E33: busy is seen on 33 sampling points.
    localparam int FULL_BUSY = 33;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    mdu dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src0  (src0),
        .src1  (src1),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge. Returns at the negedge after the accepting edge,
    // with the operands scrambled so that late source changes are exercised.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src0  = a;
        src1  = b;
        @(negedge clk);
        start = 1'b0;
        src0  = $urandom;
        src1  = $urandom;
    endtask

    task automatic wait_done(input string nm, input int exp_busy);
        int bc  = 0;
        int cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bc++;
            cyc++;
            @(negedge clk);
        end
        chk({nm, " done"}, 64'(done), 64'd1);
        chk({nm, " busy_cycles"}, 64'(bc), 64'(exp_busy));
    endtask

    task automatic move(input logic [2:0] o, input logic [31:0] d, input string nm);
        issue(o, d, 32'h0);
        chk({nm, " busy"}, 64'(busy), 64'd0);
        chk({nm, " done"}, 64'(done), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst   = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        src0  = 32'h0;
        src1  = 32'h0;

        vecs[0]  = '{MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1]  = '{MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[5]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6]  = '{MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[7]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[9]  = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[10] = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[11] = '{MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F};
        vecs[12] = '{DIVU,  32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999};
        vecs[13] = '{MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table of arithmetic vectors
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), FULL_BUSY);
            chk($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            chk($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            @(negedge clk);
            chk($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
            chk($sformatf("vec%0d busy_after", i), 64'(busy), 64'd0);
        end

        // MTHI while idle
        move(MTHI, 32'h1234_5678, "mthi");
        chk("mthi hi", 64'(hi), 64'h1234_5678);

        // MTLO and MTHI while a DIV is in flight are dropped
        issue(DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1; op = MTLO; src0 = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = MTHI; src0 = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_drop", FULL_BUSY - 8);
        chk("busy_drop hi", 64'(hi), 64'h2);
        chk("busy_drop lo", 64'(lo), 64'hE);

        // Reset in the middle of a MULT aborts it
        @(negedge clk);
        issue(MULT, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst hi", 64'(hi), 64'd0);
        chk("midrst lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst quiet busy", 64'(busy), 64'd0);
        chk("midrst quiet lo", 64'(lo), 64'd0);
        issue(MULT, 32'd3, 32'd5);
        wait_done("post_rst", FULL_BUSY);
        chk("post_rst hi", 64'(hi), 64'd0);
        chk("post_rst lo", 64'(lo), 64'd15);

        // Back-to-back: new start issued in the done cycle
        @(negedge clk);
        issue(MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done("b2b_a", FULL_BUSY);
        chk("b2b_a hi", 64'(hi), 64'h1);
        chk("b2b_a lo", 64'(lo), 64'hFFFF_FFFE);
        issue(DIVU, 32'd100, 32'd7);
        wait_done("b2b_b", FULL_BUSY);
        chk("b2b_b hi", 64'(hi), 64'h2);
        chk("b2b_b lo", 64'(lo), 64'hE);
        @(negedge clk);

        // Multiply-accumulate
        move(MTLO, 32'd10, "mtlo");
        chk("mtlo lo", 64'(lo), 64'd10);
        move(MTHI, 32'd0, "mthi0");
        chk("mthi0 hi", 64'(hi), 64'd0);
`ifdef MDU_MADD_EN
        issue(MADD, 32'hFFFF_FFFF, 32'd3);
        wait_done("madd", FULL_BUSY);
        chk("madd hi", 64'(hi), 64'd0);
        chk("madd lo", 64'(lo), 64'd7);
        @(negedge clk);
        issue(MADDU, 32'hFFFF_FFFF, 32'd3);
        wait_done("maddu", FULL_BUSY);
        chk("maddu hi", 64'(hi), 64'd3);
        chk("maddu lo", 64'(lo), 64'd4);
`else
        begin
            int act_cnt = 0;
            issue(MADD, 32'hFFFF_FFFF, 32'd3);
            for (int k = 0; k < 40; k++) begin
                if (busy !== 1'b0 || done !== 1'b0) act_cnt++;
                @(negedge clk);
            end
            chk("madd_off activity", 64'(act_cnt), 64'd0);
            chk("madd_off hi", 64'(hi), 64'd0);
            chk("madd_off lo", 64'(lo), 64'd10);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
